// File: rtl/mux_seq_pkg.sv
// Shared constants and state encoding for the mux select sequencer.
// No logic, no latency.
// No flow control.
package mux_seq_pkg;

   localparam int SEL_W  = 2;
   localparam int WORD_W = 4;

   // Two-state FSM kept as plain constants so older flows can read it
   typedef logic [0:0] state_t;
   localparam state_t IDLE  = 1'b0;
   localparam state_t SHIFT = 1'b1;

   // Select order: 00 first (mux emits in[3]), 11 last (mux emits in[0])
   localparam logic [SEL_W-1:0] SEL_FIRST = 2'b00;
   localparam logic [SEL_W-1:0] SEL_LAST  = 2'b11;

endpackage

// File: rtl/mux4x1.sv
// 4:1 select mux driven by the sequencer; s=00 picks in[3], s=11 picks in[0].
// Latency: purely combinational.
// Backpressure: none.
module mux4x1 (
   input  logic [3:0] in_i,
   input  logic [1:0] s_i,
   output logic       out_o
);

   // Inverting the select maps 00->bit 3 ... 11->bit 0
   assign out_o = in_i[~s_i];

endmodule

// File: rtl/mux_sel_sequencer.sv
// Serializes 4-bit words through the mux by stepping mux_sel 00..11, HOLD_CYCLES each.
// Latency: first select 1 cycle after accept; a word spans 4*HOLD_CYCLES cycles.
// Backpressure: in_ready = one-entry pending buffer empty; back-to-back words run gap-free.
module mux_sel_sequencer
   import mux_seq_pkg::*;
#(
   parameter int HOLD_CYCLES = 1,
   parameter int CNT_W       = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic [WORD_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [WORD_W-1:0] mux_in,
   output logic [SEL_W-1:0]  mux_sel,
   output logic              bit_stb,
   output logic              bit_last,
   output logic              busy
);

   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [SEL_W-1:0]    sel_q, sel_d;
   logic [WORD_W-1:0]   word_q, word_d;
   logic [WORD_W-1:0]   pend_q, pend_d;
   logic                pend_vld_q, pend_vld_d;
   logic                stb_q, stb_d;
   logic                last_q, last_d;
   logic                busy_q, busy_d;

   logic                accept;
   logic                hold_done;
   logic                end_of_word;

   assign in_ready    = ~pend_vld_q;
   assign accept      = in_valid & in_ready;
   assign hold_done   = (cnt_q == HOLD_LAST);
   assign end_of_word = (state_q == SHIFT) && hold_done && (sel_q == SEL_LAST);

   // Next-state: hold counter, select stepping, pending buffer and word handover
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      sel_d      = sel_q;
      word_d     = word_q;
      pend_d     = pend_q;
      pend_vld_d = pend_vld_q;
      busy_d     = busy_q;
      stb_d      = 1'b0;
      last_d     = 1'b0;

      if (flush) begin
         state_d    = IDLE;
         cnt_d      = '0;
         sel_d      = SEL_FIRST;
         word_d     = '0;
         pend_d     = '0;
         pend_vld_d = 1'b0;
         busy_d     = 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (accept) begin
                  word_d  = in_data;
                  sel_d   = SEL_FIRST;
                  cnt_d   = '0;
                  busy_d  = 1'b1;
                  state_d = SHIFT;
               end
            end
            SHIFT: begin
               if (!hold_done) begin
                  cnt_d = cnt_q + CNT_W'(1);
               end else begin
                  cnt_d = '0;
                  if (sel_q != SEL_LAST) begin
                     sel_d = sel_q + SEL_W'(1);
                  end else if (pend_vld_q) begin
                     word_d     = pend_q;
                     pend_vld_d = 1'b0;
                     sel_d      = SEL_FIRST;
                  end else if (accept) begin
                     // Word arriving on the last strobe skips the buffer
                     word_d = in_data;
                     sel_d  = SEL_FIRST;
                  end else begin
                     state_d = IDLE;
                     busy_d  = 1'b0;
                  end
               end
               // in_ready is low whenever pending is full, so this never overwrites it
               if (accept && !end_of_word) begin
                  pend_d     = in_data;
                  pend_vld_d = 1'b1;
               end
            end
            default: begin
               state_d = IDLE;
               busy_d  = 1'b0;
            end
         endcase
      end

      // Strobe is registered: raise it on entry to the final hold cycle of a select
      stb_d  = (state_d == SHIFT) && (cnt_d == HOLD_LAST);
      last_d = stb_d && (sel_d == SEL_LAST);
   end

   // State registers; reset clears any word in flight immediately
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         sel_q      <= SEL_FIRST;
         word_q     <= '0;
         pend_q     <= '0;
         pend_vld_q <= 1'b0;
         stb_q      <= 1'b0;
         last_q     <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         sel_q      <= sel_d;
         word_q     <= word_d;
         pend_q     <= pend_d;
         pend_vld_q <= pend_vld_d;
         stb_q      <= stb_d;
         last_q     <= last_d;
         busy_q     <= busy_d;
      end
   end

   assign mux_in   = word_q;
   assign mux_sel  = sel_q;
   assign bit_stb  = stb_q;
   assign bit_last = last_q;
   assign busy     = busy_q;

endmodule

// File: tb/tb_mux_sel_sequencer.sv
// Scoreboard bench: two sequencers (HOLD_CYCLES=1 and 3) each feeding a mux4x1.
// Stimulus pushes expected strobes (cycle, sel, serial bit, last) into per-instance queues;
// negedge monitors pop and compare on every bit_stb.
module tb_mux_sel_sequencer;

   typedef struct {
      int cyc;
      int sel;
      int bit_v;
      int last;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   int         cyc = 0;
   int         checks = 0;
   int         errors = 0;
   exp_t       q1[$];
   exp_t       q3[$];

   logic       flush1 = 1'b0, flush3 = 1'b0;
   logic [3:0] in_data1 = 4'h0, in_data3 = 4'h0;
   logic       in_valid1 = 1'b0, in_valid3 = 1'b0;
   logic       in_ready1, in_ready3;
   logic [3:0] mux_in1, mux_in3;
   logic [1:0] mux_sel1, mux_sel3;
   logic       bit_stb1, bit_stb3, bit_last1, bit_last3, busy1, busy3;
   logic       mo1, mo3;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   mux_sel_sequencer #(.HOLD_CYCLES(1), .CNT_W(4)) u1 (
      .clk(clk), .rst_n(rst_n), .flush(flush1), .in_data(in_data1), .in_valid(in_valid1),
      .in_ready(in_ready1), .mux_in(mux_in1), .mux_sel(mux_sel1), .bit_stb(bit_stb1),
      .bit_last(bit_last1), .busy(busy1));

   mux_sel_sequencer #(.HOLD_CYCLES(3), .CNT_W(4)) u3 (
      .clk(clk), .rst_n(rst_n), .flush(flush3), .in_data(in_data3), .in_valid(in_valid3),
      .in_ready(in_ready3), .mux_in(mux_in3), .mux_sel(mux_sel3), .bit_stb(bit_stb3),
      .bit_last(bit_last3), .busy(busy3));

   mux4x1 m1 (.in_i(mux_in1), .s_i(mux_sel1), .out_o(mo1));
   mux4x1 m3 (.in_i(mux_in3), .s_i(mux_sel3), .out_o(mo3));

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Expected strobes of a word starting its first select in cycle start+1
   task automatic push_word(input int inst, input logic [3:0] w, input int start,
                            input int h, input int n);
      exp_t e;
      for (int k = 0; k < n; k++) begin
         e.cyc   = start + (k + 1) * h;
         e.sel   = k;
         e.bit_v = int'(w[3-k]);
         e.last  = (k == 3) ? 1 : 0;
         if (inst == 1) q1.push_back(e);
         else           q3.push_back(e);
      end
   endtask

   task automatic mon(input int inst, input logic stb, input logic last,
                      input logic [1:0] sel, input logic b);
      exp_t e;
      checks++;
      if (last && !stb) begin
         errors++;
         $display("FAIL u%0d last_without_stb at cycle %0d", inst, cyc);
      end
      if (stb) begin
         checks++;
         if ((inst == 1 && q1.size() == 0) || (inst == 3 && q3.size() == 0)) begin
            errors++;
            $display("FAIL u%0d unexpected_stb at cycle %0d sel=%0d bit=%0d", inst, cyc, sel, b);
         end else begin
            e = (inst == 1) ? q1.pop_front() : q3.pop_front();
            if (cyc != e.cyc || int'(sel) != e.sel || int'(b) != e.bit_v || int'(last) != e.last) begin
               errors++;
               $display("FAIL u%0d strobe: got cyc=%0d sel=%0d bit=%0d last=%0d, want cyc=%0d sel=%0d bit=%0d last=%0d",
                        inst, cyc, sel, b, last, e.cyc, e.sel, e.bit_v, e.last);
            end
         end
      end
   endtask

   always @(negedge clk) mon(1, bit_stb1, bit_last1, mux_sel1, mo1);
   always @(negedge clk) mon(3, bit_stb3, bit_last3, mux_sel3, mo3);

   initial begin
      int a;
      // Reset / idle
      repeat (2) @(negedge clk);
      chk("rst in_ready1", int'(in_ready1), 1);
      chk("rst busy1", int'(busy1), 0);
      chk("rst sel1", int'(mux_sel1), 0);
      chk("rst mux_in1", int'(mux_in1), 0);
      chk("rst in_ready3", int'(in_ready3), 1);
      chk("rst busy3", int'(busy3), 0);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("idle in_ready1", int'(in_ready1), 1);
      chk("idle busy3", int'(busy3), 0);
      chk("idle mux_in3", int'(mux_in3), 0);

      // Single word, HOLD_CYCLES=1
      a = cyc;
      chk("t1 in_ready", int'(in_ready1), 1);
      in_data1 = 4'b0011; in_valid1 = 1'b1;
      push_word(1, 4'b0011, a, 1, 4);
      @(negedge clk); in_valid1 = 1'b0;
      chk("t1 busy", int'(busy1), 1);
      chk("t1 mux_in", int'(mux_in1), 3);
      chk("t1 sel first", int'(mux_sel1), 0);
      repeat (4) @(negedge clk);
      chk("t1 busy end", int'(busy1), 0);
      chk("t1 in_ready end", int'(in_ready1), 1);
      chk("t1 sel hold", int'(mux_sel1), 3);
      chk("t1 mux_in hold", int'(mux_in1), 3);
      @(negedge clk);

      // Hold stretch, HOLD_CYCLES=3
      a = cyc;
      in_data3 = 4'b1010; in_valid3 = 1'b1;
      push_word(3, 4'b1010, a, 3, 4);
      @(negedge clk); in_valid3 = 1'b0;
      repeat (11) @(negedge clk);
      chk("t2 busy at 12", int'(busy3), 1);
      chk("t2 last at 12", int'(bit_last3), 1);
      @(negedge clk);
      chk("t2 busy at 13", int'(busy3), 0);

      // Back-to-back, HOLD_CYCLES=1
      @(negedge clk);
      a = cyc;
      in_data1 = 4'b1100; in_valid1 = 1'b1;
      push_word(1, 4'b1100, a, 1, 4);
      push_word(1, 4'b0101, a + 4, 1, 4);
      @(negedge clk);
      chk("t3 in_ready c1", int'(in_ready1), 1);
      in_data1 = 4'b0101;
      @(negedge clk); in_valid1 = 1'b0;
      chk("t3 in_ready c2", int'(in_ready1), 0);
      @(negedge clk);
      chk("t3 in_ready c3", int'(in_ready1), 0);
      @(negedge clk);
      chk("t3 in_ready c4", int'(in_ready1), 0);
      @(negedge clk);
      chk("t3 in_ready c5", int'(in_ready1), 1);
      chk("t3 mux_in c5", int'(mux_in1), 5);
      repeat (4) @(negedge clk);
      chk("t3 busy end", int'(busy1), 0);

      // Same-cycle bypass, HOLD_CYCLES=3
      @(negedge clk);
      a = cyc;
      in_data3 = 4'b0110; in_valid3 = 1'b1;
      push_word(3, 4'b0110, a, 3, 4);
      push_word(3, 4'b1001, a + 12, 3, 4);
      @(negedge clk); in_valid3 = 1'b0;
      repeat (11) @(negedge clk);
      chk("t4 sel last", int'(mux_sel3), 3);
      chk("t4 in_ready", int'(in_ready3), 1);
      in_data3 = 4'b1001; in_valid3 = 1'b1;
      @(negedge clk); in_valid3 = 1'b0;
      chk("t4 sel restart", int'(mux_sel3), 0);
      chk("t4 mux_in new", int'(mux_in3), 9);
      chk("t4 busy", int'(busy3), 1);
      chk("t4 pending empty", int'(in_ready3), 1);
      repeat (12) @(negedge clk);
      chk("t4 busy end", int'(busy3), 0);

      // Flush at sel=01 with pending full, HOLD_CYCLES=1
      @(negedge clk);
      a = cyc;
      in_data1 = 4'b1011; in_valid1 = 1'b1;
      push_word(1, 4'b1011, a, 1, 2);
      @(negedge clk);
      in_data1 = 4'b0111;
      @(negedge clk);
      chk("t5 sel01", int'(mux_sel1), 1);
      chk("t5 pending full", int'(in_ready1), 0);
      flush1 = 1'b1; in_data1 = 4'b1111;
      @(negedge clk);
      chk("t5 busy", int'(busy1), 0);
      chk("t5 in_ready", int'(in_ready1), 1);
      chk("t5 sel", int'(mux_sel1), 0);
      chk("t5 mux_in", int'(mux_in1), 0);
      // accept attempted while flush is high must be dropped
      @(negedge clk); flush1 = 1'b0; in_valid1 = 1'b0;
      chk("t5 flush accept ignored", int'(busy1), 0);
      chk("t5 mux_in stays 0", int'(mux_in1), 0);
      repeat (3) @(negedge clk);

      // Async reset mid-word with pending full, HOLD_CYCLES=3
      a = cyc;
      in_data3 = 4'b1101; in_valid3 = 1'b1;
      push_word(3, 4'b1101, a, 3, 1);
      @(negedge clk);
      in_data3 = 4'b0010;
      @(negedge clk); in_valid3 = 1'b0;
      chk("t6 pending full", int'(in_ready3), 0);
      repeat (3) @(negedge clk);
      chk("t6 sel01", int'(mux_sel3), 1);
      #2 rst_n = 1'b0;
      #1;
      chk("t6 async busy", int'(busy3), 0);
      chk("t6 async in_ready", int'(in_ready3), 1);
      chk("t6 async sel", int'(mux_sel3), 0);
      chk("t6 async mux_in", int'(mux_in3), 0);
      chk("t6 async stb", int'(bit_stb3), 0);
      @(negedge clk); rst_n = 1'b1;
      repeat (8) @(negedge clk);
      chk("t6 stays idle", int'(busy3), 0);

      chk("q1 drained", q1.size(), 0);
      chk("q3 drained", q3.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
